// File: rtl/uart_rx_deserializer_if.sv
// Output-side bundle of the UART receive deserializer: received frame,
// its error flags, the valid/ready handshake and status pulses.
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_overrun;
  logic                 rx_busy;

  modport master (
    output rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_overrun, rx_busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_overrun, rx_busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: start-bit detection, mid-bit sampling, LSB-first
// shift, optional parity and stop check, one-entry valid/ready output register.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_sync,
  uart_rx_deserializer_if.master rx_if
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic parity_err_f(input logic [DATA_BITS-1:0] data,
                                        input logic par_bit);
    return (((^data) ^ par_bit) != (PARITY_ODD != 0));
  endfunction

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 par_pend_r, par_pend_s;
  logic                 prev_r;
  logic                 done_s, load_s, valid_s;
  logic                 bit_tick_s;
  logic [DATA_BITS-1:0] data_r;
  logic                 perr_r, ferr_r, valid_r, ovr_r, busy_r;

  // Next-state, baud counter, bit index and shift register update.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    shift_s    = shift_r;
    par_pend_s = par_pend_r;
    done_s     = 1'b0;
    bit_tick_s = (cnt_r == CNT_LAST);
    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        idx_s = '0;
        if (prev_r && !rx_sync) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_s = '0;
          if (rx_sync) begin
            state_s = ST_IDLE;
          end else begin
            state_s    = ST_DATA;
            idx_s      = '0;
            par_pend_s = 1'b0;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_tick_s) begin
          cnt_s          = '0;
          shift_s[idx_r] = rx_sync;
          if (idx_r == IDX_LAST) begin
            idx_s = '0;
            if (PARITY_EN != 0) begin
              state_s = ST_PARITY;
            end else begin
              state_s = ST_STOP;
            end
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_tick_s) begin
          cnt_s      = '0;
          par_pend_s = parity_err_f(shift_r, rx_sync);
          state_s    = ST_STOP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_tick_s) begin
          cnt_s  = '0;
          done_s = 1'b1;
          if (rx_sync) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WAIT_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_sync) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        idx_s   = '0;
      end
    endcase
  end

  // Output register load/drop decision and valid handshake.
  always_comb begin
    load_s = done_s && (!valid_r || rx_if.rx_ready);
    if (load_s) begin
      valid_s = 1'b1;
    end else if (valid_r && rx_if.rx_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

  // Receiver state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      idx_r      <= '0;
      shift_r    <= '0;
      par_pend_r <= 1'b0;
      prev_r     <= 1'b1;
      data_r     <= '0;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      valid_r    <= 1'b0;
      ovr_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      shift_r    <= shift_s;
      par_pend_r <= par_pend_s;
      prev_r     <= rx_sync;
      valid_r    <= valid_s;
      ovr_r      <= done_s && !load_s;
      busy_r     <= (state_s != ST_IDLE);
      if (load_s) begin
        data_r <= shift_r;
        perr_r <= par_pend_r;
        ferr_r <= ~rx_sync;
      end
    end
  end

  assign rx_if.rx_data       = data_r;
  assign rx_if.rx_parity_err = perr_r;
  assign rx_if.rx_frame_err  = ferr_r;
  assign rx_if.rx_valid      = valid_r;
  assign rx_if.rx_overrun    = ovr_r;
  assign rx_if.rx_busy       = busy_r;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench: an 8N1 instance and an 8E1 instance driven with hand-built frames.
module tb_uart_rx_deserializer;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1;
  logic rx_p = 1'b1;
  logic ready_a = 1'b0;
  logic ready_p = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int cyc = 0;
  int vrise_a = 0, vhi_a = 0, ovr_a = 0, t_valid_a = 0, t_busy_a = 0, t_bfall_a = 0;
  int vrise_p = 0, t_valid_p = 0, t_busy_p = 0;
  logic va_prev = 1'b0, ba_prev = 1'b0, vp_prev = 1'b0, bp_prev = 1'b0;

  uart_rx_deserializer_if #(.DATA_BITS(8)) if_a ();
  uart_rx_deserializer_if #(.DATA_BITS(8)) if_p ();
  assign if_a.rx_ready = ready_a;
  assign if_p.rx_ready = ready_p;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_sync(rx_a), .rx_if(if_a.master));
  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx_sync(rx_p), .rx_if(if_p.master));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    va_prev <= if_a.rx_valid;
    ba_prev <= if_a.rx_busy;
    vp_prev <= if_p.rx_valid;
    bp_prev <= if_p.rx_busy;
    if (if_a.rx_valid && !va_prev) begin
      vrise_a   <= vrise_a + 1;
      t_valid_a <= cyc;
    end
    if (if_a.rx_valid) vhi_a <= vhi_a + 1;
    if (if_a.rx_overrun) ovr_a <= ovr_a + 1;
    if (if_a.rx_busy && !ba_prev) t_busy_a <= cyc;
    if (!if_a.rx_busy && ba_prev) t_bfall_a <= cyc;
    if (if_p.rx_valid && !vp_prev) begin
      vrise_p   <= vrise_p + 1;
      t_valid_p <= cyc;
    end
    if (if_p.rx_busy && !bp_prev) t_busy_p <= cyc;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit sel, input logic b);
    if (sel) rx_p = b;
    else rx_a = b;
    wait_cycles(CPB);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input bit with_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
    if (with_par) drive_bit(sel, par_bit);
    drive_bit(sel, stop_bit);
  endtask

  task automatic test_reset();
    wait_cycles(3);
    checks++;
    if ({if_a.rx_data, if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_valid,
         if_a.rx_overrun, if_a.rx_busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs_a: got data=%h pe=%b fe=%b v=%b ov=%b busy=%b, want all 0",
               if_a.rx_data, if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_valid,
               if_a.rx_overrun, if_a.rx_busy);
    end
    checks++;
    if ({if_p.rx_data, if_p.rx_valid, if_p.rx_busy} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs_p: got data=%h v=%b busy=%b, want 0", if_p.rx_data,
               if_p.rx_valid, if_p.rx_busy);
    end
    rst_n = 1'b1;
    wait_cycles(5);
    checks++;
    if (if_a.rx_busy !== 1'b0 || if_a.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, want 0 0", if_a.rx_busy, if_a.rx_valid);
    end
  endtask

  task automatic test_basic_8n1();
    int vr0, vh0;
    ready_a = 1'b1;
    vr0 = vrise_a;
    vh0 = vhi_a;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_cycles(5);
    checks++;
    if (t_valid_a - t_busy_a !== 152) begin
      errors++;
      $display("FAIL latency_8n1: got %0d cycles, want 152", t_valid_a - t_busy_a);
    end
    checks++;
    if (if_a.rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL data_A5: got %h, want a5", if_a.rx_data);
    end
    checks++;
    if (if_a.rx_parity_err !== 1'b0 || if_a.rx_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL flags_A5: got pe=%b fe=%b, want 0 0", if_a.rx_parity_err, if_a.rx_frame_err);
    end
    checks++;
    if (vrise_a - vr0 !== 1 || vhi_a - vh0 !== 1) begin
      errors++;
      $display("FAIL valid_pulse_A5: got rises=%0d high_cycles=%0d, want 1 1",
               vrise_a - vr0, vhi_a - vh0);
    end
    checks++;
    if (if_a.rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_A5: got %b, want 0", if_a.rx_busy);
    end
  endtask

  task automatic test_glitch();
    int vr0, ov0;
    vr0 = vrise_a;
    ov0 = ovr_a;
    rx_a = 1'b0;
    wait_cycles(3);
    rx_a = 1'b1;
    wait_cycles(20);
    checks++;
    if (t_bfall_a - t_busy_a !== 8) begin
      errors++;
      $display("FAIL glitch_busy_len: got %0d cycles, want 8", t_bfall_a - t_busy_a);
    end
    checks++;
    if (vrise_a - vr0 !== 0 || ovr_a - ov0 !== 0) begin
      errors++;
      $display("FAIL glitch_no_output: got valid_rises=%0d overruns=%0d, want 0 0",
               vrise_a - vr0, ovr_a - ov0);
    end
    checks++;
    if (if_a.rx_busy !== 1'b0 || if_a.rx_valid !== 1'b0 || if_a.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: busy=%b valid=%b ovr=%b, want 0 0 0", if_a.rx_busy,
               if_a.rx_valid, if_a.rx_overrun);
    end
  endtask

  task automatic test_break();
    int vr0;
    vr0 = vrise_a;
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_cycles(100);
    checks++;
    if (if_a.rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL break_wait_idle: busy=%b, want 1", if_a.rx_busy);
    end
    checks++;
    if (if_a.rx_data !== 8'h00 || if_a.rx_frame_err !== 1'b1 || if_a.rx_parity_err !== 1'b0) begin
      errors++;
      $display("FAIL break_frame: got data=%h fe=%b pe=%b, want 00 1 0", if_a.rx_data,
               if_a.rx_frame_err, if_a.rx_parity_err);
    end
    rx_a = 1'b1;
    wait_cycles(30);
    checks++;
    if (vrise_a - vr0 !== 1 || if_a.rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL break_single_frame: got frames=%0d busy=%b, want 1 0", vrise_a - vr0,
               if_a.rx_busy);
    end
  endtask

  task automatic test_parity();
    ready_p = 1'b1;
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    wait_cycles(5);
    checks++;
    if (if_p.rx_data !== 8'h03 || if_p.rx_parity_err !== 1'b1 || if_p.rx_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad: got data=%h pe=%b fe=%b, want 03 1 0", if_p.rx_data,
               if_p.rx_parity_err, if_p.rx_frame_err);
    end
    checks++;
    if (t_valid_p - t_busy_p !== 168) begin
      errors++;
      $display("FAIL latency_8e1: got %0d cycles, want 168", t_valid_p - t_busy_p);
    end
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    wait_cycles(5);
    checks++;
    if (if_p.rx_data !== 8'h03 || if_p.rx_parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_good: got data=%h pe=%b, want 03 0", if_p.rx_data, if_p.rx_parity_err);
    end
    checks++;
    if (vrise_p !== 2) begin
      errors++;
      $display("FAIL parity_frames: got %0d frames, want 2", vrise_p);
    end
  endtask

  task automatic test_overrun();
    int ov0;
    ready_a = 1'b0;
    ov0 = ovr_a;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    wait_cycles(5);
    checks++;
    if (if_a.rx_valid !== 1'b1 || if_a.rx_data !== 8'h11) begin
      errors++;
      $display("FAIL hold_11: got valid=%b data=%h, want 1 11", if_a.rx_valid, if_a.rx_data);
    end
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    wait_cycles(5);
    checks++;
    if (if_a.rx_valid !== 1'b1 || if_a.rx_data !== 8'h11) begin
      errors++;
      $display("FAIL overrun_keeps_11: got valid=%b data=%h, want 1 11", if_a.rx_valid,
               if_a.rx_data);
    end
    checks++;
    if (ovr_a - ov0 !== 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d high cycles, want 1", ovr_a - ov0);
    end
    ready_a = 1'b1;
    wait_cycles(1);
    checks++;
    if (if_a.rx_valid !== 1'b0 || if_a.rx_data !== 8'h11) begin
      errors++;
      $display("FAIL accept_11: got valid=%b data=%h, want 0 11", if_a.rx_valid, if_a.rx_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int vr0;
    ready_a = 1'b0;
    send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    wait_cycles(5);
    checks++;
    if (if_a.rx_valid !== 1'b1 || if_a.rx_data !== 8'h77) begin
      errors++;
      $display("FAIL hold_77: got valid=%b data=%h, want 1 77", if_a.rx_valid, if_a.rx_data);
    end
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    rx_a = 1'b0;
    wait_cycles(5);
    checks++;
    if (if_a.rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_data: got %b, want 1", if_a.rx_busy);
    end
    rst_n = 1'b0;
    rx_a = 1'b1;
    #2;
    checks++;
    if ({if_a.rx_data, if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_valid,
         if_a.rx_overrun, if_a.rx_busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_frame: got data=%h pe=%b fe=%b v=%b ov=%b busy=%b, want all 0",
               if_a.rx_data, if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_valid,
               if_a.rx_overrun, if_a.rx_busy);
    end
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(10);
    vr0 = vrise_a;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_cycles(5);
    checks++;
    if (if_a.rx_valid !== 1'b1 || if_a.rx_data !== 8'h3C || if_a.rx_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL data_3C: got valid=%b data=%h fe=%b, want 1 3c 0", if_a.rx_valid,
               if_a.rx_data, if_a.rx_frame_err);
    end
    checks++;
    if (vrise_a - vr0 !== 1) begin
      errors++;
      $display("FAIL frames_after_reset: got %0d, want 1", vrise_a - vr0);
    end
    ready_a = 1'b1;
    wait_cycles(1);
    checks++;
    if (if_a.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_3C: got valid=%b, want 0", if_a.rx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_glitch();
    test_break();
    test_parity();
    test_overrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- UART receive datapath stage. It sits directly downstream of the 3-stage rx bit synchronizer and consumes that synchronizer's output.
- Detects the start bit, samples each bit at mid-bit using an internal baud counter, and shifts data in LSB first.
- Checks optional parity and the stop bit.
- Presents each completed frame, with its error flags, in a one-entry output register that uses a valid/ready handshake.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit. Legal range is 4 or more. HALF = CLKS_PER_BIT/2, using integer division.
- DATA_BITS, 8, data bits per frame. Legal range is 5 to 9.
- PARITY_EN, 0, when 1 a parity bit follows the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_sync  input  1  synchronized serial line; idle level is 1
- rx_data  output  DATA_BITS  received data word, LSB = first bit on the wire
- rx_parity_err  output  1  parity mismatch for the frame held in rx_data
- rx_frame_err  output  1  stop bit sampled as 0 for the frame held in rx_data
- rx_valid  output  1  output register holds an unconsumed frame
- rx_ready  input  1  consumer accepts the frame when rx_valid && rx_ready
- rx_overrun  output  1  one-cycle pulse: a completed frame was dropped because the output register was full
- rx_busy  output  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous on rst_n low:
  - State = IDLE; baud counter = 0; bit index = 0; shift register = 0.
  - Registered previous-rx = 1.
  - rx_data = 0; rx_parity_err = 0; rx_frame_err = 0; rx_valid = 0; rx_overrun = 0; rx_busy = 0.
  - Reset mid-frame discards the partial frame and any held frame.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - A falling edge (previous-rx = 1 and rx_sync = 0) moves to START with the baud counter cleared.
- START:
  - The counter counts up each cycle. At count HALF-1 the line is sampled and the counter is cleared.
  - Sample = 1: false start; return to IDLE with no output activity.
  - Sample = 0: go to DATA with bit index = 0.
- DATA:
  - At count CLKS_PER_BIT-1, sample rx_sync into shift register position [bit index], then clear the counter.
  - After bit index reaches DATA_BITS-1, go to PARITY if PARITY_EN=1, otherwise to STOP.
  - Sample points therefore fall at HALF + k*CLKS_PER_BIT cycles after the edge-detect cycle, for k = 1..DATA_BITS.
- PARITY:
  - At count CLKS_PER_BIT-1, compute err = (XOR of data bits XOR sampled bit) != PARITY_ODD, then go to STOP.
  - With PARITY_EN=0, err = 0.
- STOP:
  - At count CLKS_PER_BIT-1, sample the stop bit and complete the frame. "Complete frame" means:
    - If rx_valid = 0, or rx_ready = 1 in the same cycle, load rx_data, rx_parity_err and rx_frame_err (= stop sample was 0), and set rx_valid = 1 on the next edge.
    - Otherwise drop the new frame, pulse rx_overrun for one cycle, and keep the held frame and its flags unchanged.
  - Stop sample = 1: go to IDLE.
  - Stop sample = 0: go to WAIT_IDLE.
- WAIT_IDLE:
  - Remain here until rx_sync = 1, then go to IDLE. This covers break conditions: one break produces exactly one frame with rx_frame_err = 1.
- Edge detection after completion:
  - Previous-rx is updated every cycle.
  - A start edge is recognised only in IDLE. The earliest next-frame detection is therefore the cycle after returning to IDLE.
- Output handshake:
  - rx_valid clears on the edge after rx_valid && rx_ready, unless a new frame loads on that same cycle, in which case rx_valid stays 1 with the new data.
  - rx_data and the flags are stable while rx_valid = 1 and rx_ready = 0.
- Latency: rx_valid rises one cycle after the stop-bit sample cycle.
- The baud counter is $clog2(CLKS_PER_BIT) bits wide and never exceeds CLKS_PER_BIT-1. The bit index is $clog2(DATA_BITS) bits wide.

Test Plan:
1. Defaults (CLKS_PER_BIT=16, 8N1): send 0xA5 with rx_ready=1 -> rx_valid rises 1 cycle after the stop sample (152 cycles after the edge-detect cycle); rx_data=0xA5, both error flags 0, one-cycle rx_valid.
2. Glitch: drive rx_sync 0 for 3 cycles, then 1 -> returns to IDLE after 8 cycles; rx_valid, rx_overrun and rx_busy stay low after that.
3. Stop bit forced 0, then line held low for 100 cycles, then high -> one frame with rx_frame_err=1; state stays in WAIT_IDLE until the line goes high; no second frame.
4. PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit 1 -> rx_parity_err=1. Send 0x03 with parity bit 0 -> rx_parity_err=0.
5. rx_ready=0: send 0x11, then 0x22 -> rx_data stays 0x11, rx_overrun pulses once at the 0x22 stop sample. Raise rx_ready -> 0x11 accepted, rx_valid drops.
6. Assert rst_n low during DATA of 0x5A -> all outputs at reset values. The next clean frame 0x3C is received correctly.
